// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_mux
// Function : Scans four BCD digits onto a common-anode 4-digit seven-segment
//            display with anti-ghost blanking, adjust-digit blink and colon dp.
// Revision : 1.0 - initial release
// ============================================================================
module display_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] min_l,
    input  logic [4:0] min_r,
    input  logic [4:0] sec_l,
    input  logic [4:0] sec_r,
    input  logic       adjusting,
    input  logic [2:0] adj_sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int RC_W = $clog2(REFRESH_DIV + 1);
    localparam int BC_W = $clog2(BLINK_DIV + 1);

    localparam logic [RC_W-1:0] C_RC_MAX = RC_W'(REFRESH_DIV - 1);
    localparam logic [RC_W-1:0] C_BLANK  = RC_W'(BLANK_CYCLES);
    localparam logic [BC_W-1:0] C_BC_MAX = BC_W'(BLINK_DIV - 1);
    localparam logic [6:0]      C_SEG_OFF = 7'b1111111;

    logic [RC_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            blink_ph_q, blink_ph_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;
    logic [4:0]      digit;

    function automatic logic [6:0] decode(input logic [4:0] v);
        logic [6:0] s;
        case (v)
            5'd0:    s = 7'b1000000;
            5'd1:    s = 7'b1111001;
            5'd2:    s = 7'b0100100;
            5'd3:    s = 7'b0110000;
            5'd4:    s = 7'b0011001;
            5'd5:    s = 7'b0010010;
            5'd6:    s = 7'b0000010;
            5'd7:    s = 7'b1111000;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        idx_d         = idx_q;
        if (refresh_cnt_q == C_RC_MAX) begin
            refresh_cnt_d = '0;
            idx_d         = idx_q + 2'd1;
        end

        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == C_BC_MAX) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end

        case (idx_q)
            2'd0:    digit = min_l;
            2'd1:    digit = min_r;
            2'd2:    digit = sec_l;
            default: digit = sec_r;
        endcase

        // Outputs are computed from the present state so they lag it by one cycle.
        an_d  = 4'b1111;
        seg_d = C_SEG_OFF;
        dp_d  = 1'b1;
        if (refresh_cnt_q >= C_BLANK) begin
            an_d  = ~(4'b1000 >> idx_q);
            dp_d  = (idx_q != 2'd1);
            if (adjusting && blink_ph_q && (adj_sel == {1'b0, idx_q})) begin
                seg_d = C_SEG_OFF;
            end else begin
                seg_d = decode(digit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            blink_cnt_q   <= '0;
            idx_q         <= '0;
            blink_ph_q    <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= C_SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            idx_q         <= idx_d;
            blink_ph_q    <= blink_ph_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_mux
// Function : Scoreboard bench for display_mux with an independent scan model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_mux;

    localparam int C_RD = 4;
    localparam int C_BL = 1;
    localparam int C_BD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] min_l, min_r, sec_l, sec_r;
    logic       adjusting;
    logic [2:0] adj_sel;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 clk = ~clk;

    display_mux #(
        .REFRESH_DIV (C_RD),
        .BLANK_CYCLES(C_BL),
        .BLINK_DIV   (C_BD)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .min_l    (min_l),
        .min_r    (min_r),
        .sec_l    (sec_l),
        .sec_r    (sec_r),
        .adjusting(adjusting),
        .adj_sel  (adj_sel),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "reset";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] ref_decode(input logic [4:0] v);
        case (v)
            5'd0: return 7'b1000000;
            5'd1: return 7'b1111001;
            5'd2: return 7'b0100100;
            5'd3: return 7'b0110000;
            5'd4: return 7'b0011001;
            5'd5: return 7'b0010010;
            5'd6: return 7'b0000010;
            5'd7: return 7'b1111000;
            5'd8: return 7'b0000000;
            5'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Reference scan model; one expected {an,seg,dp} pushed per rising edge.
    int          m_cnt = 0, m_idx = 0, m_bcnt = 0;
    bit          m_ph  = 1'b0;
    logic [11:0] exp_q[$];
    logic [11:0] m_exp;
    logic [4:0]  m_dig;

    always @(posedge clk) begin
        if (rst) begin
            m_exp  = {4'b1111, 7'b1111111, 1'b1};
            m_cnt  = 0;
            m_idx  = 0;
            m_bcnt = 0;
            m_ph   = 1'b0;
        end else begin
            case (m_idx)
                0:       m_dig = min_l;
                1:       m_dig = min_r;
                2:       m_dig = sec_l;
                default: m_dig = sec_r;
            endcase
            if (m_cnt < C_BL) begin
                m_exp = {4'b1111, 7'b1111111, 1'b1};
            end else begin
                m_exp[11:8] = ~(4'b1000 >> m_idx);
                m_exp[7:1]  = (adjusting && m_ph && (int'(adj_sel) == m_idx))
                              ? 7'b1111111 : ref_decode(m_dig);
                m_exp[0]    = (m_idx == 1) ? 1'b0 : 1'b1;
            end
            if (m_cnt == C_RD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            if (m_bcnt == C_BD - 1) begin
                m_bcnt = 0;
                m_ph   = ~m_ph;
            end else begin
                m_bcnt++;
            end
        end
        exp_q.push_back(m_exp);
    end

    int          blink_hits   = 0;
    int          other_blanks = 0;
    int          lit_blanks   = 0;
    logic [11:0] sb_exp;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            check(phase, {20'd0, an, seg, dp}, {20'd0, sb_exp});
            if (an == 4'b1101 && seg == 7'b1111111) blink_hits++;
            if (an != 4'b1111 && an != 4'b1101 && seg == 7'b1111111) other_blanks++;
            if (an != 4'b1111 && seg == 7'b1111111) lit_blanks++;
        end
    end

    task automatic first_lit_latency(input string tag);
        int c = 0;
        while (an !== 4'b0111 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check(tag, c, C_BL + 1);
    endtask

    task automatic wait_state(input string tag, input int idx, input int cnt);
        int c = 0;
        while (!(m_idx == idx && m_cnt == cnt) && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) check({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
        adjusting = 1'b0; adj_sel = 3'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        phase = "first_scan";
        first_lit_latency("first_lit");
        repeat (8 * C_RD) @(negedge clk);

        phase = "decode";
        for (int v = 0; v < 16; v++) begin
            min_l = 5'(v);
            repeat (4 * C_RD) @(negedge clk);
        end
        min_l = 5'd1;

        phase = "blink";
        adjusting = 1'b1; adj_sel = 3'd2; sec_l = 5'd5;
        @(negedge clk);
        blink_hits = 0; other_blanks = 0;
        repeat (64) @(negedge clk);
        check("blink_seen", 32'(blink_hits > 0), 1);
        check("blink_others", other_blanks, 0);

        phase = "no_target";
        adj_sel = 3'd5;
        @(negedge clk);
        lit_blanks = 0;
        repeat (64) @(negedge clk);
        check("no_target_blank", lit_blanks, 0);

        phase = "reset_mid";
        adjusting = 1'b0;
        wait_state("reset_mid", 2, 2);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_an", {28'd0, an}, 32'hF);
        rst = 1'b0;
        first_lit_latency("reset_mid_lit");

        phase = "live";
        sec_r = 5'd8;
        wait_state("live", 3, 2);
        check("live_before", {25'd0, seg}, 32'(7'b0000000));
        sec_r = 5'd9;
        @(negedge clk);
        check("live_after", {25'd0, seg}, 32'(7'b0010000));
        check("live_an", {28'd0, an}, 32'(4'b1110));
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_mux.md
# display_mux

Time-multiplexed seven-segment driver that sits directly downstream of the stopwatch digit counter. It takes the four BCD digits (min_l, min_r, sec_l, sec_r), scans them one at a time onto a common-anode 4-digit display, and blinks the digit under adjustment. It also drives the decimal point that separates minutes from seconds.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (≥2); at 100 MHz this gives a 1 kHz slot rate.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off, for anti-ghosting (1 ≤ BLANK_CYCLES < REFRESH_DIV).
- BLINK_DIV, 25000000: cycles per blink half-period (≥1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- min_l  in  5  minutes tens digit, unsigned.
- min_r  in  5  minutes ones digit, unsigned.
- sec_l  in  5  seconds tens digit, unsigned.
- sec_r  in  5  seconds ones digit, unsigned.
- adjusting  in  1  1 = adjust mode active.
- adj_sel  in  3  digit under adjustment: 0=min_l, 1=min_r, 2=sec_l, 3=sec_r; values 4–7 select none.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  anodes, active-low; an[3]=min_l (leftmost) … an[0]=sec_r.

## Operation
- State:
  - refresh_cnt: 0..REFRESH_DIV-1, wraps.
  - idx: 2 bits, 0..3.
  - blink_cnt: 0..BLINK_DIV-1, wraps.
  - blink_ph: 1 bit.
- Scan: refresh_cnt increments every cycle. When refresh_cnt == REFRESH_DIV-1, it wraps to 0 and idx increments mod 4 (3→0).
- Slot mapping:
  - idx 0 → min_l, an=0111
  - idx 1 → min_r, an=1011
  - idx 2 → sec_l, an=1101
  - idx 3 → sec_r, an=1110
- Blanking: while refresh_cnt < BLANK_CYCLES, an=1111, seg=1111111, dp=1.
- Decode of the selected 5-bit value:
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10–31 → dash 0111111
- Blink: blink_cnt increments every cycle. On reaching BLINK_DIV-1 it wraps to 0 and blink_ph toggles. If adjusting=1, adj_sel==idx and blink_ph=1, then seg=1111111 for that slot. The anode still follows the slot mapping.
- adj_sel ≥4 with adjusting=1: no digit blinks.
- dp: 0 during idx 1 non-blanked cycles (min/sec separator), else 1. dp is not affected by blink.
- Digit inputs are sampled combinationally in the slot where they are shown. Changes mid-slot appear on the next output update; no input latching.
- Reset:
  - refresh_cnt, blink_cnt, idx and blink_ph clear to 0.
  - Outputs go to an=1111, seg=1111111, dp=1.
  - Reset mid-slot aborts the slot immediately, with no partial-slot carry.

## Timing
- All outputs are registered. Outputs in cycle n+1 reflect the state and inputs at edge n, giving a fixed 1-cycle latency.
- Slot length is exactly REFRESH_DIV cycles:
  - BLANK_CYCLES cycles with all anodes off,
  - then REFRESH_DIV-BLANK_CYCLES cycles with one anode on.
- Full scan period: 4·REFRESH_DIV cycles. Full blink period: 2·BLINK_DIV cycles.
- After rst deasserts, the first non-blank output (an=0111) appears BLANK_CYCLES+1 cycles later.
- Wrap cases:
  - idx 3→0 and a blink_ph toggle on the same edge are independent; both take effect.
  - rst asserted on the same edge as a wrap has priority over the wrap.
- Blink and scan counters are free-running; neither is gated by adjusting.

## Test plan
Bench parameters: REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_DIV=8.

- **Reset and first scan.** Stimulus: rst=1 for 2 cycles with digits 1,2,3,4, then release. Required: an=1111/seg=1111111/dp=1 while in reset; then the an sequence 1111, 0111×3, 1111, 1011×3 (dp=0), 1111, 1101×3, 1111, 1110×3, repeating; seg shows 1111001, 0100100, 0110000, 0011001.
- **Decode sweep.** Stimulus: hold adjusting=0 and drive min_l through 0–15, one value per full scan. Required: seg in the idx 0 slot matches the table; values 10–15 give 0111111.
- **Blink.** Stimulus: adjusting=1, adj_sel=2, sec_l=5. Required: the sec_l slot shows 0010010 while blink_ph=0 and 1111111 while blink_ph=1 (phase flips every 8 cycles); the other digits never blank outside the blanking cycles.
- **No-target adjust.** Stimulus: adjusting=1, adj_sel=5. Required: all four digits display continuously, with no blinking.
- **Reset mid-slot.** Stimulus: assert rst at refresh_cnt=2, idx=2. Required: the next output is an=1111; after release the scan restarts at idx 0, and the first lit slot is an=0111 after 2 cycles.
- **Live update.** Stimulus: change sec_r 8→9 during an idx 3 lit cycle. Required: seg changes 0000000→0010000 one cycle later, within the same slot.
